sata_rx_prim_decode: RTL

SATA_RX_PRIM_DECODE -- requirements
Module: sata_rx_prim_decode

---
 rtl/sata_rx_prim_decode.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sata_rx_prim_decode.sv
// Purpose: decodes received SATA dwords into primitives and frame payload, with CONT expansion and frame tracking.
// Latency: every output is registered; each input dword produces its response exactly 1 phyclk later.
// Backpressure: none. A dword is consumed every phyclk, and the downstream logic must accept every output cycle.
//
// Ports:
//   phyclk, phyreset          PHY word clock and synchronous active-high reset
//   rxdata, rxdatak, linkup   received dword, primitive qualifier, and link-up qualifier (linkup=0 acts as reset)
//   prim_vld, prim_code       decoded primitive strobe and code (CONT repeats the last primitive)
//   data_out, data_vld        frame payload dword and its qualifier (data_out holds when data_vld=0)
//   sof_pls, eof_pls          frame start and frame end strobes
//   frame_len                 payload dword count of the last completed frame (saturates at 0xFFFF)
//   err_unknown/stray/cont    unknown primitive, stray data or SOF, and CONT without a history

module sata_rx_prim_decode (
    input  logic        phyclk,
    input  logic        phyreset,
    input  logic [31:0] rxdata,
    input  logic        rxdatak,
    input  logic        linkup,
    output logic        prim_vld,
    output logic [4:0]  prim_code,
    output logic [31:0] data_out,
    output logic        data_vld,
    output logic        sof_pls,
    output logic        eof_pls,
    output logic [15:0] frame_len,
    output logic        err_unknown,
    output logic        err_stray,
    output logic        err_cont
);

    localparam logic [4:0] C_ALIGN = 5'd0,  C_CONT  = 5'd1,  C_SYNC  = 5'd2;
    localparam logic [4:0] C_SOF   = 5'd7,  C_EOF   = 5'd8,  C_X_RDY = 5'd9;
    localparam logic [4:0] C_WTRM  = 5'd10;

    typedef enum logic {IDLE, IN_FRAME} frame_state_t;

    frame_state_t state, nxt_state;
    logic [15:0]  cnt, nxt_cnt;
    logic         cont_active, nxt_cont_active;
    logic         last_vld, nxt_last_vld;
    logic [4:0]   last_code, nxt_last_code;

    logic         nxt_prim_vld, nxt_data_vld, nxt_sof, nxt_eof;
    logic         nxt_err_unknown, nxt_err_stray, nxt_err_cont;
    logic [4:0]   nxt_prim_code;
    logic [31:0]  nxt_data_out;
    logic [15:0]  nxt_frame_len;

    // Exact 32-bit primitive match
    logic         dec_hit;
    logic [4:0]   dec_code;

    always_comb begin
        dec_hit  = 1'b1;
        dec_code = C_ALIGN;
        case (rxdata)
            32'h7B4A4ABC: dec_code = C_ALIGN;
            32'h9999AA7C: dec_code = C_CONT;
            32'hB5B5957C: dec_code = C_SYNC;
            32'h4A4A957C: dec_code = 5'd3;
            32'h5555B57C: dec_code = 5'd4;
            32'h3535B57C: dec_code = 5'd5;
            32'h5656B57C: dec_code = 5'd6;
            32'h3737B57C: dec_code = C_SOF;
            32'hD5D5B57C: dec_code = C_EOF;
            32'h5757B57C: dec_code = C_X_RDY;
            32'h5858B57C: dec_code = C_WTRM;
            32'hD5D5AA7C: dec_code = 5'd11;
            32'h9595AA7C: dec_code = 5'd12;
            32'h3636B57C: dec_code = 5'd13;
            32'h1717B57C: dec_code = 5'd14;
            32'h7575957C: dec_code = 5'd15;
            32'h9595957C: dec_code = 5'd16;
            32'hF5F5957C: dec_code = 5'd17;
            default:      dec_hit  = 1'b0;
        endcase
    end

    logic is_cont, is_prim, is_unknown, is_data;
    assign is_cont    = rxdatak &  dec_hit & (dec_code == C_CONT);
    assign is_prim    = rxdatak &  dec_hit & (dec_code != C_CONT) & (dec_code != C_ALIGN);
    assign is_unknown = rxdatak & ~dec_hit;
    assign is_data    = ~rxdatak;

    // State register; linkup loss behaves exactly like reset
    always_ff @(posedge phyclk) begin
        if (phyreset || !linkup) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            cont_active <= 1'b0;
            last_vld    <= 1'b0;
            last_code   <= 5'd0;
        end else begin
            state       <= nxt_state;
            cnt         <= nxt_cnt;
            cont_active <= nxt_cont_active;
            last_vld    <= nxt_last_vld;
            last_code   <= nxt_last_code;
        end
    end

    // Next-state logic. ALIGN falls through every branch and leaves all state untouched.
    always_comb begin
        nxt_state       = state;
        nxt_cnt         = cnt;
        nxt_cont_active = cont_active;
        nxt_last_vld    = last_vld;
        nxt_last_code   = last_code;
        if (is_prim) begin
            nxt_last_vld    = 1'b1;
            nxt_last_code   = dec_code;
            nxt_cont_active = 1'b0;
            case (dec_code)
                C_SOF: begin
                    nxt_state = IN_FRAME;
                    nxt_cnt   = 16'd0;
                end
                C_EOF, C_SYNC, C_X_RDY, C_WTRM: nxt_state = IDLE;
                default: ;
            endcase
        end else if (is_cont) begin
            if (last_vld) begin
                nxt_cont_active = 1'b1;
            end
        end else if (is_unknown) begin
            nxt_cont_active = 1'b0;
        end else if (is_data && !cont_active && state == IN_FRAME) begin
            nxt_cnt = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
        end
    end

    // Output logic, computed one cycle ahead of the output registers
    always_comb begin
        nxt_prim_vld    = 1'b0;
        nxt_prim_code   = prim_code;
        nxt_data_vld    = 1'b0;
        nxt_data_out    = data_out;
        nxt_sof         = 1'b0;
        nxt_eof         = 1'b0;
        nxt_frame_len   = frame_len;
        nxt_err_unknown = 1'b0;
        nxt_err_stray   = 1'b0;
        nxt_err_cont    = 1'b0;
        if (is_prim) begin
            nxt_prim_vld  = 1'b1;
            nxt_prim_code = dec_code;
            if (dec_code == C_SOF) begin
                nxt_sof       = (state == IDLE);
                nxt_err_stray = (state == IN_FRAME);
            end else if (dec_code == C_EOF && state == IN_FRAME) begin
                nxt_eof       = 1'b1;
                nxt_frame_len = cnt;
            end
        end else if (is_cont) begin
            if (last_vld) begin
                nxt_prim_vld  = 1'b1;
                nxt_prim_code = last_code;
            end else begin
                nxt_err_cont = 1'b1;
            end
        end else if (is_unknown) begin
            nxt_err_unknown = 1'b1;
        end else if (is_data) begin
            // While CONT is active, junk dwords repeat the last primitive instead of carrying payload
            if (cont_active) begin
                nxt_prim_vld  = 1'b1;
                nxt_prim_code = last_code;
            end else if (state == IN_FRAME) begin
                nxt_data_vld = 1'b1;
                nxt_data_out = rxdata;
            end else begin
                nxt_err_stray = 1'b1;
            end
        end
    end

    always_ff @(posedge phyclk) begin
        if (phyreset || !linkup) begin
            prim_vld    <= 1'b0;
            prim_code   <= 5'd0;
            data_vld    <= 1'b0;
            data_out    <= 32'd0;
            sof_pls     <= 1'b0;
            eof_pls     <= 1'b0;
            frame_len   <= 16'd0;
            err_unknown <= 1'b0;
            err_stray   <= 1'b0;
            err_cont    <= 1'b0;
        end else begin
            prim_vld    <= nxt_prim_vld;
            prim_code   <= nxt_prim_code;
            data_vld    <= nxt_data_vld;
            data_out    <= nxt_data_out;
            sof_pls     <= nxt_sof;
            eof_pls     <= nxt_eof;
            frame_len   <= nxt_frame_len;
            err_unknown <= nxt_err_unknown;
            err_stray   <= nxt_err_stray;
            err_cont    <= nxt_err_cont;
        end
    end

endmodule
